// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the MIPS IF stage and its fetch buffer.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} fetch_state_e;

  // One buffered fetch: PC+4 of the word and the word itself
  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO decoupling instruction-memory latency from ID stalls.
module fetch_buffer #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  // The fetch FSM only requests while space is guaranteed
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && full));

endmodule

// File: rtl/fetch_stage.sv
// IF stage + IF/ID register: PC, req/ack fetch FSM, fetch buffer, freeze and redirect.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instruction_out,
  output logic        valid_out
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_e state, state_nxt;
  logic [31:0]  pc, pc_nxt, addr_nxt;
  logic         req_nxt;
  logic         push, pop, buf_full, buf_empty, room_after;
  logic [CW-1:0] buf_count;
  fetch_entry_t push_entry, head;

  assign pop        = !freeze && !branch_taken && !buf_empty;
  assign push       = (state == WAIT) && imem_ack && !branch_taken;
  assign push_entry = '{pc4: pc + 32'd4, instr: imem_rdata};
  // Space left once this cycle's push and pop have both landed
  assign room_after = (buf_count + CW'(push) - CW'(pop)) < CW'(BUF_DEPTH);

  fetch_buffer #(.DEPTH(BUF_DEPTH), .WIDTH(64)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (branch_taken),
    .wdata (push_entry),
    .head  (head),
    .full  (buf_full),
    .empty (buf_empty),
    .count (buf_count)
  );

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    req_nxt   = imem_req;
    addr_nxt  = imem_addr;
    if (branch_taken) begin
      pc_nxt = branch_addr;
      if (state != IDLE) begin
        if (imem_ack) begin
          req_nxt   = 1'b0;
          state_nxt = IDLE;
        end else begin
          state_nxt = DRAIN;
        end
      end
    end else begin
      case (state)
        IDLE: if (!buf_full) begin
          req_nxt   = 1'b1;
          addr_nxt  = pc;
          state_nxt = WAIT;
        end
        WAIT: if (imem_ack) begin
          pc_nxt = pc + 32'd4;
          if (room_after) begin
            addr_nxt = pc + 32'd4;
          end else begin
            req_nxt   = 1'b0;
            state_nxt = IDLE;
          end
        end
        DRAIN: if (imem_ack) begin
          req_nxt   = 1'b0;
          state_nxt = IDLE;
        end
        default: begin
          req_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      pc              <= RESET_PC;
      imem_req        <= 1'b0;
      imem_addr       <= RESET_PC;
      pc_out          <= '0;
      instruction_out <= NOP_INSTR;
      valid_out       <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      imem_req  <= req_nxt;
      imem_addr <= addr_nxt;
      if (branch_taken || (!freeze && buf_empty)) begin
        pc_out          <= '0;
        instruction_out <= NOP_INSTR;
        valid_out       <= 1'b0;
      end else if (!freeze) begin
        pc_out          <= head.pc4;
        instruction_out <= head.instr;
        valid_out       <= 1'b1;
      end
    end
  end

endmodule
